// File: rtl/sb_packet_serializer_if.sv
// Sideband packet serializer bus: the parallel producer handshake on one side
// and the serial stream with its clock-enable on the other.
interface sb_packet_serializer_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] in_data;
    logic             in_data_valid;
    logic             in_data_ready;
    logic             out_data;
    logic             out_clk_en;
    logic             busy;

    // Producer / observer side
    modport master (
        output in_data, in_data_valid,
        input  in_data_ready, out_data, out_clk_en, busy
    );

    // Serializer side
    modport slave (
        input  in_data, in_data_valid,
        output in_data_ready, out_data, out_clk_en, busy
    );
endinterface

// File: rtl/sb_packet_serializer.sv
// Sideband packet serializer: takes a WIDTH-bit packet, shifts it out LSB
// first with out_clk_en high for each bit, then holds the line idle for GAP
// cycles before the next packet may start. Every output is a flop fed from
// next-state logic, so nothing downstream sees a combinational glitch and
// in_data_ready has no path from in_data_valid.
module sb_packet_serializer #(
    parameter int WIDTH   = 64,
    parameter int WIDTH_W = 6,
    parameter int GAP     = 32,
    parameter int GAP_W   = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    sb_packet_serializer_if.slave  sb
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP_ST = 2'd2
    } state_t;

    localparam logic [WIDTH_W-1:0] LAST_BIT = WIDTH_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0]   LAST_GAP = GAP_W'(GAP - 1);

    state_t             state, state_n;
    logic [WIDTH-1:0]   sr, sr_n;
    logic [WIDTH_W-1:0] bit_cnt, bit_cnt_n;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
    logic               hs;

    // Next-state decode; a handshake is only possible where ready is already high
    always_comb begin
        state_n   = state;
        sr_n      = sr;
        bit_cnt_n = bit_cnt;
        gap_cnt_n = gap_cnt;
        hs        = sb.in_data_valid && sb.in_data_ready;
        case (state)
            IDLE: begin
                if (hs) begin
                    sr_n      = sb.in_data;
                    bit_cnt_n = '0;
                    state_n   = SEND;
                end
            end
            SEND: begin
                sr_n      = sr >> 1;
                bit_cnt_n = bit_cnt + 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    gap_cnt_n = '0;
                    state_n   = GAP_ST;
                end
            end
            GAP_ST: begin
                // wraps harmlessly when GAP == 2^GAP_W: we leave GAP that cycle
                gap_cnt_n = gap_cnt + 1'b1;
                if (gap_cnt == LAST_GAP) begin
                    if (hs) begin
                        sr_n      = sb.in_data;
                        bit_cnt_n = '0;
                        state_n   = SEND;
                    end else begin
                        state_n   = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, counters and registered outputs, all derived from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            sr               <= '0;
            bit_cnt          <= '0;
            gap_cnt          <= '0;
            sb.out_data      <= 1'b0;
            sb.out_clk_en    <= 1'b0;
            sb.busy          <= 1'b0;
            sb.in_data_ready <= 1'b1;
        end else begin
            state            <= state_n;
            sr               <= sr_n;
            bit_cnt          <= bit_cnt_n;
            gap_cnt          <= gap_cnt_n;
            sb.out_data      <= (state_n == SEND) && sr_n[0];
            sb.out_clk_en    <= (state_n == SEND);
            sb.busy          <= (state_n != IDLE);
            sb.in_data_ready <= (state_n == IDLE) ||
                                ((state_n == GAP_ST) && (gap_cnt_n == LAST_GAP));
        end
    end

endmodule

// File: doc/sb_packet_serializer.md
SB_PACKET_SERIALIZER -- requirements
Module: sb_packet_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning bits per sideband packet.
REQ-002 SHALL have parameter WIDTH_W, default 6, meaning bit-counter width, equal to log2(WIDTH).
REQ-003 SHALL have parameter GAP, default 32, meaning idle cycles inserted after each packet; legal range 1..2^GAP_W.
REQ-004 SHALL have parameter GAP_W, default 6, meaning gap-counter width.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port in_data, input, WIDTH, the parallel packet to send.
REQ-008 SHALL have port in_data_valid, input, 1, meaning the producer offers in_data.
REQ-009 SHALL have port in_data_ready, output, 1, meaning the block accepts in_data this cycle.
REQ-010 SHALL have port out_data, output, 1, the serial bit stream.
REQ-011 SHALL have port out_clk_en, output, 1, high exactly in cycles where out_data carries a packet bit; downstream uses it to gate the sideband clock.
REQ-012 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, SEND and GAP.
REQ-014 SHALL perform a handshake on a rising edge where in_data_valid and in_data_ready are both 1: it latches in_data into a WIDTH-bit shift register, clears the bit counter and enters SEND.
REQ-015 SHALL drive in_data_ready to 1 in IDLE, and in GAP when the gap counter equals GAP-1; otherwise in_data_ready SHALL be 0.
REQ-016 SHALL drive in_data_ready only from registered state, with no combinational path from in_data_valid.
REQ-017 SHALL ignore in_data and in_data_valid when in_data_ready is 0; valid may deassert without a handshake.
REQ-018 SHALL, in SEND, drive out_data to shift-register bit 0 (LSB first) and out_clk_en to 1.
REQ-019 SHALL, at each SEND edge, shift the register right by one and increment the bit counter.
REQ-020 SHALL, in SEND with bit counter equal to WIDTH-1, go to GAP and clear the gap counter.
REQ-021 SHALL, in GAP and IDLE, drive out_data to 0 and out_clk_en to 0.
REQ-022 SHALL, in GAP, increment the gap counter each cycle.
REQ-023 SHALL, at gap counter GAP-1, go to SEND if a handshake occurs, else go to IDLE.
REQ-024 SHALL give latency: handshake at edge N puts bit 0 on out_data in the cycle after edge N, and bit WIDTH-1 in the cycle after edge N+WIDTH-1.
REQ-025 SHALL, with in_data_valid held high, produce a packet period of exactly WIDTH+GAP cycles (64 high and 32 low out_clk_en cycles at defaults).
REQ-026 SHALL keep out_data and out_clk_en decoded only from registers, so they are glitch-free.
REQ-027 SHALL never assert out_clk_en for more than WIDTH consecutive cycles.

Reset
REQ-028 SHALL, while rst is high, immediately force state IDLE, counters 0, shift register 0, out_data 0, out_clk_en 0, busy 0 and in_data_ready 1.
REQ-029 SHALL, on reset mid-packet, discard the partial packet; after release, the next handshake sends from bit 0.

Verification
REQ-030 SHALL verify reset: assert rst -> out_clk_en=0, out_data=0, busy=0, in_data_ready=1.
REQ-031 SHALL verify a single packet: in_data=64'hA5A5_0000_FFFF_0001 with one-cycle valid -> bits LSB first (1,0,0,...), out_clk_en high for exactly 64 cycles then 32 low, with ready high on the 32nd gap cycle.
REQ-032 SHALL verify back-to-back packets: valid held with packets 64'h1 then 64'h8000_0000_0000_0000 -> second packet's first bit appears exactly 96 cycles after the first packet's first bit.
REQ-033 SHALL verify that in_data changes while valid is high during SEND: only the value at the handshake edge is transmitted and ready stays 0 throughout SEND.
REQ-034 SHALL verify reset mid-packet: rst pulsed during bit 20 -> out_clk_en drops within the same cycle; after release, packet 64'h3 sends 1,1,0,... from bit 0.
REQ-035 SHALL verify the GAP=1 override: valid held -> exactly one low out_clk_en cycle between packets, for a period of 65 cycles.
